// File: rtl/umacc.sv
// Unsigned multiply-accumulate stage: hin*COEF summed into a saturating accumulator,
// scaled by SHIFT and saturated to 15 bits. Define UMACC_ROUND_EN for round-half-up scaling.
module umacc #(
  parameter int unsigned COEF  = 1,
  parameter int unsigned ACC_W = 40,
  parameter int unsigned SHIFT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [14:0] hin,
  output logic [14:0] hout
);

  localparam int unsigned      EXT_W     = ACC_W + 1;
  localparam logic [14:0]      COEF_C    = 15'(COEF);
  localparam logic [ACC_W-1:0] ACC_MAX_C = '1;
  localparam logic [EXT_W-1:0] SAT_LIM_C = EXT_W'(15'h7FFF);
`ifdef UMACC_ROUND_EN
  localparam int unsigned      HALF_POS  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [EXT_W-1:0] HALF_C    = (SHIFT > 0) ? (EXT_W'(1'b1) << HALF_POS) : '0;
`else
  localparam logic [EXT_W-1:0] HALF_C    = '0;
`endif

  // Clamp a scaled accumulator value into the 15-bit output range.
  function automatic logic [14:0] sat15(input logic [EXT_W-1:0] v);
    logic [14:0] r;
    if (v > SAT_LIM_C) begin
      r = 15'h7FFF;
    end else begin
      r = v[14:0];
    end
    return r;
  endfunction

  logic [14:0]      in_r;
  logic [29:0]      prod_r;
  logic [ACC_W-1:0] acc_r;
  logic [29:0]      prod_s;
  logic [EXT_W-1:0] sum_s;
  logic [ACC_W-1:0] acc_nxt_s;
  logic [EXT_W-1:0] scaled_s;
  logic [14:0]      hout_nxt_s;

  // Product and saturating accumulate; the extra sum bit flags overflow.
  always_comb begin
    prod_s = 30'(in_r) * 30'(COEF_C);
    sum_s  = {1'b0, acc_r} + EXT_W'(prod_r);
    if (sum_s[ACC_W]) begin
      acc_nxt_s = ACC_MAX_C;
    end else begin
      acc_nxt_s = sum_s[ACC_W-1:0];
    end
  end

  // Output scaling; the rounding bias is added one bit wider so it never wraps.
  always_comb begin
    scaled_s   = ({1'b0, acc_r} + HALF_C) >> SHIFT;
    hout_nxt_s = sat15(scaled_s);
  end

  // Four-stage pipeline: input, product, accumulator, output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_r   <= 15'd0;
      prod_r <= 30'd0;
      acc_r  <= '0;
      hout   <= 15'd0;
    end else begin
      in_r   <= hin;
      prod_r <= prod_s;
      acc_r  <= acc_nxt_s;
      hout   <= hout_nxt_s;
    end
  end

endmodule

// File: tb/tb_umacc.sv
// Scoreboard bench for umacc: several parameterisations share clock, reset and hin;
// a behavioural model predicts hout and a monitor compares after every rising edge.
module tb_umacc;

  localparam int N = 6;
  localparam int unsigned PC [N] = '{1, 3, 32767, 1, 32767, 5000};
  localparam int unsigned PA [N] = '{40, 40, 30, 40, 30, 48};
  localparam int unsigned PS [N] = '{0, 0, 0, 2, 15, 20};

  typedef logic [N-1:0][14:0] exp_t;

  logic        clock;
  logic        reset;
  logic [14:0] hin;
  logic [14:0] hout_a [N];

  exp_t              expq [$];
  longint unsigned   acc_m [N];
  int                checks;
  int                failures;
  bit                armed;

  genvar g;
  for (g = 0; g < N; g++) begin : g_dut
    umacc #(.COEF(PC[g]), .ACC_W(PA[g]), .SHIFT(PS[g])) u_dut (
      .clock(clock),
      .reset(reset),
      .hin  (hin),
      .hout (hout_a[g])
    );
  end

  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  // Reference: total of hin*COEF, pinned at 2^ACC_W-1, then scaled and clamped.
  function automatic logic [14:0] model_out(input int i);
    longint unsigned half;
    longint unsigned v;
    half = 0;
`ifdef UMACC_ROUND_EN
    if (PS[i] > 0) half = longint'(1) << (PS[i] - 1);
`endif
    v = (acc_m[i] + half) >> PS[i];
    if (v > 32767) return 15'h7FFF;
    return v[14:0];
  endfunction

  task automatic check_zero(input string name);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (hout_a[i] !== 15'd0) begin
        failures++;
        $display("FAIL %s dut%0d got=%0d exp=0", name, i, hout_a[i]);
      end
    end
  endtask

  // Drive one sample at a falling edge and queue the output it will produce.
  task automatic step(input logic [14:0] v);
    exp_t e;
    longint unsigned lim;
    hin = v;
    for (int i = 0; i < N; i++) begin
      lim = (longint'(1) << PA[i]) - 1;
      acc_m[i] = acc_m[i] + longint'(v) * longint'(PC[i]);
      if (acc_m[i] > lim) acc_m[i] = lim;
      e[i] = model_out(i);
    end
    expq.push_back(e);
    @(negedge clock);
  endtask

  task automatic apply_reset(input bit mid);
    if (mid) #3;
    reset = 1'b1;
    #1;
    check_zero(mid ? "async_reset_mid" : "reset");
    expq.delete();
    for (int i = 0; i < N; i++) acc_m[i] = 0;
    hin = 15'd0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) expq.push_back('0);
  endtask

  // Monitor: pops one expectation per rising edge outside reset.
  always @(posedge clock) begin
    #1;
    if (armed) begin
      if (reset) begin
        check_zero("hold_in_reset");
      end else if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow got=empty exp=entry");
      end else begin
        exp_t e;
        e = expq.pop_front();
        for (int i = 0; i < N; i++) begin
          checks++;
          if (hout_a[i] !== e[i]) begin
            failures++;
            $display("FAIL hout dut%0d t=%0t got=%0d exp=%0d", i, $time, hout_a[i], e[i]);
          end
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    armed    = 1'b0;
    reset    = 1'b0;
    hin      = 15'd0;
    for (int i = 0; i < N; i++) acc_m[i] = 0;
    @(negedge clock);
    apply_reset(1'b0);
    armed = 1'b1;
    repeat (4) step(15'd0);
    // Ramp, interrupted by an asynchronous reset, then restarted.
    repeat (40) step(15'd1);
    apply_reset(1'b1);
    repeat (12) step(15'd1);
    // Constant multiply.
    apply_reset(1'b0);
    repeat (8) step(15'd100);
    // Single pulse exercises scaling/rounding.
    apply_reset(1'b0);
    step(15'd6);
    repeat (8) step(15'd0);
    // Random small then full-range samples, including saturation.
    apply_reset(1'b0);
    repeat (200) step(15'($urandom_range(0, 63)));
    apply_reset(1'b1);
    repeat (200) step(15'($urandom));
    repeat (4) step(15'h7FFF);
    repeat (6) step(15'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
